// File: rtl/serial_xor_feeder.sv
// serial_xor_feeder
// Operand stage for the serial XOR unit. It accepts an A/B word pair over a
// valid/ready handshake and sends the pair out one bit at a time, LSB first.
// Each bit pair is held for one 5-cycle frame, aligned to the XOR unit's
// C0..C4 sequence. In each C4 cycle of an active frame the block raises
// bit_valid and puts the bit index on bit_idx, so the downstream collector
// knows which bit the XOR unit's xo output belongs to.
module serial_xor_feeder #(
    parameter int W = 8,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          a,
    output logic          b,
    input  logic          xor_ready,
    output logic          bit_valid,
    output logic [IW-1:0] bit_idx,
    output logic          done,
    output logic          busy,
    output logic          sync_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state_r;
    logic [2:0]    p_r;
    logic [IW-1:0] idx_r;

    // Bit 0 of each operand register always holds the next bit to present.
    logic [W-1:0]  opa_r;
    logic [W-1:0]  opb_r;

    logic          a_r;
    logic          b_r;
    logic          done_r;
    logic          sync_err_r;
    logic          in_ready_r;
    logic          busy_r;

    logic          p_is4_s;
    logic          last_bit_s;

    assign p_is4_s    = (p_r == 3'd4);
    assign last_bit_s = (idx_r == IW'(W - 1));

    assign a         = a_r;
    assign b         = b_r;
    assign done      = done_r;
    assign sync_err  = sync_err_r;
    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign bit_idx   = idx_r;
    assign bit_valid = (state_r == ST_RUN) && p_is4_s;

    // Phase counter: mirrors the XOR unit sequence, and xor_ready forces it back to C0.
    // The sticky sync_err flag records any cycle where the two disagree.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_r        <= 3'd0;
            sync_err_r <= 1'b0;
        end else begin
            if (xor_ready || p_is4_s) begin
                p_r <= 3'd0;
            end else begin
                p_r <= p_r + 3'd1;
            end
            if (p_is4_s != xor_ready) begin
                sync_err_r <= 1'b1;
            end
        end
    end

    // Control FSM: accepts a word, waits for a frame boundary, then shifts out one bit per frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            opa_r      <= '0;
            opb_r      <= '0;
            a_r        <= 1'b0;
            b_r        <= 1'b0;
            done_r     <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    a_r <= 1'b0;
                    b_r <= 1'b0;
                    if (in_valid) begin
                        idx_r      <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (p_is4_s) begin
                            // Frame boundary is on the next edge: present bit 0 now.
                            a_r     <= in_a[0];
                            b_r     <= in_b[0];
                            opa_r   <= in_a >> 1'b1;
                            opb_r   <= in_b >> 1'b1;
                            state_r <= ST_RUN;
                        end else begin
                            opa_r   <= in_a;
                            opb_r   <= in_b;
                            state_r <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (p_is4_s) begin
                        a_r     <= opa_r[0];
                        b_r     <= opb_r[0];
                        opa_r   <= opa_r >> 1'b1;
                        opb_r   <= opb_r >> 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (p_is4_s) begin
                        if (last_bit_s) begin
                            a_r        <= 1'b0;
                            b_r        <= 1'b0;
                            done_r     <= 1'b1;
                            idx_r      <= '0;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            a_r   <= opa_r[0];
                            b_r   <= opb_r[0];
                            opa_r <= opa_r >> 1'b1;
                            opb_r <= opb_r >> 1'b1;
                            idx_r <= idx_r + IW'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    idx_r      <= '0;
                    a_r        <= 1'b0;
                    b_r        <= 1'b0;
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_xor_feeder.sv
// Directed testbench for serial_xor_feeder, with one W=4 instance and one W=1 instance.
// The XOR unit is modelled here as a free-running C0..C4 counter that drives
// xor_ready in its C4 cycle. The xo value it would produce is a ^ b.
module tb_serial_xor_feeder;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       force_xr = 1'b0;
    logic [2:0] tb_p;
    logic       xor_ready;

    logic       in_valid = 1'b0;
    logic [3:0] in_a = 4'd0;
    logic [3:0] in_b = 4'd0;
    logic       in_ready, a, b, bit_valid, done, busy, sync_err;
    logic [1:0] bit_idx;

    logic       in_valid1 = 1'b0;
    logic [0:0] in_a1 = 1'b0;
    logic [0:0] in_b1 = 1'b0;
    logic       in_ready1, a1, b1, bit_valid1, done1, busy1, sync_err1;
    logic [0:0] bit_idx1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Model of the XOR unit sequence counter
    always @(posedge clk or negedge rstn) begin
        if (!rstn) tb_p <= 3'd0;
        else if (xor_ready) tb_p <= 3'd0;
        else tb_p <= tb_p + 3'd1;
    end

    assign xor_ready = force_xr | (tb_p == 3'd4);

    serial_xor_feeder #(.W(4)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .a(a), .b(b), .xor_ready(xor_ready),
        .bit_valid(bit_valid), .bit_idx(bit_idx), .done(done), .busy(busy),
        .sync_err(sync_err)
    );

    serial_xor_feeder #(.W(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .a(a1), .b(b1), .xor_ready(xor_ready),
        .bit_valid(bit_valid1), .bit_idx(bit_idx1), .done(done1), .busy(busy1),
        .sync_err(sync_err1)
    );

    // Advance to #1 after a rising edge in a cycle where the modelled phase equals tgt.
    task automatic wait_p(input int tgt);
        int n = 0;
        @(posedge clk); #1;
        while (tb_p != 3'(tgt) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #10;
        checks++; if ({a, b} !== 2'b00) begin errors++; $display("FAIL reset_ab got %b want 00", {a, b}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid got %b want 0", bit_valid); end
        checks++; if (bit_idx !== 2'd0) begin errors++; $display("FAIL reset_bit_idx got %0d want 0", bit_idx); end
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_rel_in_ready got %b want 1", in_ready); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_rel_in_ready1 got %b want 1", in_ready1); end
    endtask

    task automatic test_basic();
        logic [3:0] va = 4'b1010;
        logic [3:0] vb = 4'b0110;
        logic [3:0] xo_exp = 4'b1100;
        int k, ph, nvalid;
        nvalid = 0;
        wait_p(1);
        in_valid = 1'b1; in_a = va; in_b = vb;
        @(posedge clk); #1 in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
        // Three ARM cycles (phases 2,3,4), then 20 RUN cycles
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy cyc=%0d got busy=%b rdy=%b want 1/0", i, busy, in_ready); end
            if (i < 3) begin
                checks++; if ({a, b, bit_valid} !== 3'b000) begin errors++; $display("FAIL basic_arm cyc=%0d got %b want 000", i, {a, b, bit_valid}); end
            end else begin
                k = (i - 3) / 5; ph = (i - 3) % 5;
                checks++; if ({a, b} !== {va[k], vb[k]}) begin errors++; $display("FAIL basic_ab cyc=%0d got %b want %b", i, {a, b}, {va[k], vb[k]}); end
                checks++; if (bit_valid !== (ph == 4)) begin errors++; $display("FAIL basic_bit_valid cyc=%0d got %b want %b", i, bit_valid, ph == 4); end
                if (ph == 4) begin
                    nvalid++;
                    checks++; if (bit_idx !== 2'(k)) begin errors++; $display("FAIL basic_bit_idx got %0d want %0d", bit_idx, k); end
                    checks++; if ((a ^ b) !== xo_exp[k]) begin errors++; $display("FAIL basic_xo bit=%0d got %b want %b", k, a ^ b, xo_exp[k]); end
                end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early cyc=%0d got %b want 0", i, done); end
            end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done); end
        checks++; if ({in_ready, busy, a, b} !== 4'b1000) begin errors++; $display("FAIL basic_idle got %b want 1000", {in_ready, busy, a, b}); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_once got %b want 0", done); end
        checks++; if (nvalid !== 4) begin errors++; $display("FAIL basic_nvalid got %0d want 4", nvalid); end
    endtask

    task automatic test_accept_p4();
        logic [3:0] va = 4'b0101;
        logic [3:0] vb = 4'b0011;
        wait_p(4);
        in_valid = 1'b1; in_a = va; in_b = vb;
        @(posedge clk); #1 in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if ({a, b} !== {va[i/5], vb[i/5]}) begin errors++; $display("FAIL p4_ab cyc=%0d got %b want %b", i, {a, b}, {va[i/5], vb[i/5]}); end
            checks++; if (bit_valid !== (i % 5 == 4)) begin errors++; $display("FAIL p4_bit_valid cyc=%0d got %b want %b", i, bit_valid, i % 5 == 4); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL p4_done got %b want 1", done); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va = 4'b0011;
        logic [3:0] vb = 4'b0101;
        int k, ph;
        wait_p(1);
        in_valid = 1'b1; in_a = va; in_b = vb;
        // Hold in_valid high with decoy operands while the first word is busy
        @(posedge clk); #1 in_a = 4'b1001; in_b = 4'b0110;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                k = (i - 3) / 5;
                checks++; if ({a, b} !== {va[k], vb[k]}) begin errors++; $display("FAIL b2b_first_ab cyc=%0d got %b want %b", i, {a, b}, {va[k], vb[k]}); end
            end else begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_first_busy cyc=%0d got %b want 1", i, busy); end
            end
        end
        @(posedge clk); #1 in_a = 4'b1111; in_b = 4'b0000;
        @(negedge clk);
        checks++; if ({done, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_done_cycle got %b want 11", {done, in_ready}); end
        @(posedge clk); #1 in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i < 4) begin
                checks++; if ({busy, a, b, bit_valid} !== 4'b1000) begin errors++; $display("FAIL b2b_arm cyc=%0d got %b want 1000", i, {busy, a, b, bit_valid}); end
            end else begin
                k = (i - 4) / 5; ph = (i - 4) % 5;
                checks++; if ({a, b} !== 2'b10) begin errors++; $display("FAIL b2b_ab cyc=%0d got %b want 10", i, {a, b}); end
                checks++; if (bit_valid !== (ph == 4)) begin errors++; $display("FAIL b2b_bit_valid cyc=%0d got %b want %b", i, bit_valid, ph == 4); end
                if (ph == 4) begin
                    checks++; if (bit_idx !== 2'(k) || (a ^ b) !== 1'b1) begin errors++; $display("FAIL b2b_xo got idx=%0d xo=%b want idx=%0d xo=1", bit_idx, a ^ b, k); end
                end
            end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
    endtask

    task automatic test_w1();
        wait_p(4);
        in_valid1 = 1'b1; in_a1 = 1'b1; in_b1 = 1'b0;
        @(posedge clk); #1 in_valid1 = 1'b0; in_a1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({a1, b1, busy1} !== 3'b101) begin errors++; $display("FAIL w1_ab cyc=%0d got %b want 101", i, {a1, b1, busy1}); end
            checks++; if (bit_valid1 !== (i == 4)) begin errors++; $display("FAIL w1_bit_valid cyc=%0d got %b want %b", i, bit_valid1, i == 4); end
            if (i == 4) begin
                checks++; if (bit_idx1 !== 1'b0 || (a1 ^ b1) !== 1'b1) begin errors++; $display("FAIL w1_xo got idx=%0d xo=%b want idx=0 xo=1", bit_idx1, a1 ^ b1); end
            end
        end
        @(negedge clk);
        checks++; if ({done1, busy1, in_ready1} !== 3'b101) begin errors++; $display("FAIL w1_done got %b want 101", {done1, busy1, in_ready1}); end
        @(negedge clk);
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL w1_done_once got %b want 0", done1); end
    endtask

    task automatic test_force_sync();
        @(negedge clk);
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_pre got %b want 0", sync_err); end
        wait_p(4);
        in_valid = 1'b1; in_a = 4'b0001; in_b = 4'b0000;
        @(posedge clk); #1 in_valid = 1'b0; in_a = 4'd0;
        wait_p(2);
        force_xr = 1'b1;
        @(negedge clk);
        checks++; if ({sync_err, bit_valid} !== 2'b00) begin errors++; $display("FAIL sync_force_cycle got %b want 00", {sync_err, bit_valid}); end
        @(posedge clk); #1 force_xr = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_sticky cyc=%0d got %b want 1", i, sync_err); end
            if (i <= 5) begin
                checks++; if (bit_valid !== (i == 5)) begin errors++; $display("FAIL sync_restart cyc=%0d got %b want %b", i, bit_valid, i == 5); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] va = 4'b0110;
        logic [3:0] vb = 4'b0101;
        logic [3:0] xo_exp = 4'b0011;
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rmid_sync_clear got %b want 0", sync_err); end
        wait_p(4);
        in_valid = 1'b1; in_a = 4'b0100; in_b = 4'b0110;
        @(posedge clk); #1 in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
        repeat (11) begin @(posedge clk); #1; end
        checks++; if ({bit_idx, busy, a, b} !== 5'b10111) begin errors++; $display("FAIL rmid_pre got %b want 10111", {bit_idx, busy, a, b}); end
        rstn = 1'b0;
        #1;
        checks++; if ({a, b, in_ready, busy, done} !== 5'b00100) begin errors++; $display("FAIL rmid_reset got %b want 00100", {a, b, in_ready, busy, done}); end
        @(posedge clk); #1 rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_no_done cyc=%0d got %b want 00", i, {done, busy}); end
        end
        wait_p(4);
        in_valid = 1'b1; in_a = va; in_b = vb;
        @(posedge clk); #1 in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if ({a, b} !== {va[i/5], vb[i/5]}) begin errors++; $display("FAIL rmid_ab cyc=%0d got %b want %b", i, {a, b}, {va[i/5], vb[i/5]}); end
            if (i % 5 == 4) begin
                checks++; if (bit_valid !== 1'b1 || bit_idx !== 2'(i / 5) || (a ^ b) !== xo_exp[i/5]) begin
                    errors++; $display("FAIL rmid_xo cyc=%0d got v=%b idx=%0d xo=%b want v=1 idx=%0d xo=%b", i, bit_valid, bit_idx, a ^ b, i / 5, xo_exp[i/5]);
                end
            end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_done got %b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accept_p4();
        test_back_to_back();
        test_w1();
        test_force_sync();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_xor_feeder.md
Name: serial_xor_feeder

Overview:
- Upstream operand stage for the serial XOR unit.
- Accepts a pair of W-bit operand words over a valid/ready handshake.
- Presents the words bit-serially (LSB first) on single-bit `a`/`b` lines, one bit pair per 5-cycle frame, aligned to the XOR unit's free-running C0..C4 sequence.
- Drives `bit_valid`/`bit_idx` during each C4 cycle, telling the downstream collector which bit the XOR unit's `xo` output belongs to.

Parameters:
- W, 8, operand word width in bits (W >= 1).

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low; the same net that resets the XOR unit.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  feeder can accept an operand pair.
- in_a  input  W  operand A word.
- in_b  input  W  operand B word.
- a  output  1  serial A bit to the XOR unit (registered).
- b  output  1  serial B bit to the XOR unit (registered).
- xor_ready  input  1  the XOR unit's ready output; high only in its C4 cycle.
- bit_valid  output  1  high in the C4 cycle of an active frame; `xo` is valid for bit `bit_idx`.
- bit_idx  output  $clog2(W) (min 1)  index of the bit in the current frame.
- done  output  1  one-cycle pulse after the last frame of a word completes.
- busy  output  1  word accepted and not yet fully presented.
- sync_err  output  1  sticky phase-mismatch flag.

Behaviour:
- Reset (async, rstn=0):
  - phase p=0, state IDLE, idx=0.
  - a=b=0, done=0, sync_err=0, in_ready=1 after release.
  - Operand registers cleared.
  - Reset mid-word abandons the word; no done pulse.
- Phase counter p (0..4) mirrors the XOR unit state; both leave reset at 0.
  - Normally p <= (p==4) ? 0 : p+1.
  - If xor_ready=1, p <= 0 regardless of the current value.
- sync_err <= 1 in any cycle where (p==4) != xor_ready; it stays set until reset.
- States:
  - IDLE: in_ready=1, busy=0, a=b=0.
    - On in_valid & in_ready: capture in_a/in_b, idx<=0.
    - If p==4 in that cycle: go to RUN and load a<=in_a[0], b<=in_b[0].
    - Otherwise: go to ARM.
  - ARM: in_ready=0, busy=1. When p==4: a<=opA[0], b<=opB[0], go to RUN.
  - RUN: in_ready=0, busy=1.
    - a/b hold their value for all 5 cycles of the frame (p=0..4).
    - At p==4 with idx<W-1: idx<=idx+1, load bit idx+1.
    - At p==4 with idx==W-1: a<=b<=0, done<=1 for the next cycle, go to IDLE, idx<=0.
- Frame and output rules:
  - a/b change only on the clock edge leaving p==4, so they are stable through C0..C3 of every frame.
  - bit_valid = (state==RUN) && (p==4), combinational.
  - bit_idx = idx.
- Latency:
  - The first frame starts at the first p==0 after acceptance (0..4 cycles of wait).
  - A word occupies exactly 5*W cycles in RUN.
  - done is asserted on the p==0 cycle following the last frame.
- Handshake:
  - A new word can be accepted on the done cycle (in_ready=1 in IDLE).
  - in_valid while busy is ignored; in_a/in_b are don't-care unless accepted.
- Resync in RUN/ARM: frame transitions use the internal p==4 only. A forced p reset shortens the current frame, and that bit's result is undefined; sync_err flags it.

Test Plan:
- W=4; reset, then in_a=4'b1010, in_b=4'b0110 accepted at p==1.
  - Expected: ARM for 3 cycles, then RUN for 20 cycles.
  - With a serial_xor instance, xo at the bit_valid cycles reads 0,0,1,1 for bit_idx 0..3.
  - done pulses once, 1 cycle after the last bit_valid.
- Accept at p==4: RUN entered on the next edge with no ARM cycle; the a=in_a[0] value is stable for 5 cycles.
- Back-to-back words: in_valid held high with new operands {4'b1111, 4'b0000} on the done cycle.
  - Expected: accepted at done (p==0), 4-cycle ARM, xo reads 1,1,1,1.
  - in_valid asserted while busy produces no capture.
- Force xor_ready=1 at p==2 (no serial_xor): sync_err rises the next cycle and stays high; p restarts at 0 on the following edge.
- Assert rstn=0 mid-RUN at bit_idx=2: a=b=0, in_ready=1, busy=0 immediately; no done pulse; the next accepted word starts cleanly from bit 0.
- W=1, in_a=1, in_b=0: one frame, xo=1 with bit_idx=0, then done.
